// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined operand selectors.
// Holds default widths, the select-width derivation and the handshake
// occupancy encoding used by skid_buf.
package pipe_pkg;

    localparam int DATA_W    = 32;
    localparam int MUX_N_DEF = 4;

    // Select width for an n-way mux; never narrower than one bit.
    function automatic int sel_w_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Occupancy of the main/skid register pair.
    typedef enum logic [1:0] {
        HS_EMPTY = 2'd0,
        HS_ONE   = 2'd1,
        HS_FULL  = 2'd2
    } hs_state_e;

endpackage

// File: rtl/pipe_mux_n_skid_buf.sv
// Two-entry valid/ready skid buffer: main register M drives the output,
// skid register S catches the one beat that arrives while M is stalled.
// in_ready comes straight from a flop so out_ready never reaches it
// combinationally.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   HS_EMPTY | M and S invalid, accepting
//   HS_ONE   | M valid, S invalid, accepting
//   HS_FULL  | M and S valid, not accepting
module skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    hs_state_e        state_q;
    logic [WIDTH-1:0] m_data_q;
    logic [WIDTH-1:0] s_data_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Occupancy FSM; data registers and both handshake outputs are
    // updated together so out_valid/in_ready are pure flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HS_EMPTY;
            m_data_q    <= '0;
            s_data_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                HS_EMPTY: begin
                    if (in_xfer) begin
                        m_data_q    <= in_data;
                        out_valid_q <= 1'b1;
                        state_q     <= HS_ONE;
                    end
                end
                HS_ONE: begin
                    case ({in_xfer, out_xfer})
                        2'b10: begin
                            s_data_q   <= in_data;
                            in_ready_q <= 1'b0;
                            state_q    <= HS_FULL;
                        end
                        2'b01: begin
                            out_valid_q <= 1'b0;
                            state_q     <= HS_EMPTY;
                        end
                        2'b11: begin
                            m_data_q <= in_data;
                        end
                        default: begin
                        end
                    endcase
                end
                HS_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_xfer) begin
                        m_data_q   <= s_data_q;
                        in_ready_q <= 1'b1;
                        state_q    <= HS_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= HS_EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = m_data_q;

endmodule

// File: rtl/pipe_mux_n.sv
// Registered N-way lane selector with valid/ready handshake.
// A binary select picks one packed lane; the result is buffered in a
// two-entry skid buffer. Selects beyond the last lane yield zero data.
// Build option PIPE_MUX_SELCHK_EN adds a sticky out-of-range select flag
// (sel_err); without it sel_err is tied low and no check logic exists.
module pipe_mux_n
    import pipe_pkg::*;
#(
    parameter  int WIDTH = DATA_W,
    parameter  int N_IN  = MUX_N_DEF,
    localparam int SEL_W = sel_w_f(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    logic [WIDTH-1:0] sel_val;

    // Lane select; an index with no matching lane leaves the zero default.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_val = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (sel_val),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

`ifdef PIPE_MUX_SELCHK_EN
    logic in_xfer;
    logic sel_oor;
    logic sel_err_q;

    assign in_xfer = in_valid & in_ready;
    assign sel_oor = (32'(in_sel) >= 32'(N_IN));

    // Sticky flag: any accepted beat with a bad select sets it until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (in_xfer && sel_oor) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
module tb_pipe_mux_n;

    logic clk;
    logic rst_n;

    // 4-lane instance
    logic [31:0]  lane4 [4];
    logic [127:0] in_data4;
    logic [1:0]   in_sel4;
    logic         in_valid4, in_ready4, out_valid4, out_ready4, sel_err4;
    logic [31:0]  out_data4;

    // 3-lane instance (non power of two)
    logic [31:0]  lane3 [3];
    logic [95:0]  in_data3;
    logic [1:0]   in_sel3;
    logic         in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
    logic [31:0]  out_data3;

    int tests = 0;
    int fails = 0;

    // Reference model: FIFO of at most two accepted words.
    logic [31:0] exp_q [$];

`ifdef PIPE_MUX_SELCHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    assign in_data4 = {lane4[3], lane4[2], lane4[1], lane4[0]};
    assign in_data3 = {lane3[2], lane3[1], lane3[0]};

    pipe_mux_n #(.WIDTH(32), .N_IN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_sel(in_sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .sel_err(sel_err4)
    );

    pipe_mux_n #(.WIDTH(32), .N_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and update the model for u_dut4; returns #1 after the edge.
    task automatic cycle();
        bit          ix, ox;
        logic [31:0] v;
        ix = in_valid4 && (exp_q.size() < 2);
        ox = (exp_q.size() > 0) && out_ready4;
        v  = lane4[in_sel4];
        @(posedge clk);
        if (ox) void'(exp_q.pop_front());
        if (ix) exp_q.push_back(v);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid4 = 0; out_ready4 = 0; in_sel4 = 0;
        in_valid3 = 0; out_ready3 = 0; in_sel3 = 0;
        for (int i = 0; i < 4; i++) lane4[i] = 32'h0;
        for (int i = 0; i < 3; i++) lane3[i] = 32'h0;
        #12;
        tests++; if (out_valid4 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", out_valid4); end
        tests++; if (out_data4 !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h exp 0", out_data4); end
        tests++; if (in_ready4 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b exp 1", in_ready4); end
        tests++; if (sel_err4 !== 1'b0) begin fails++; $display("FAIL reset_sel_err got %0b exp 0", sel_err4); end
        tests++; if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0) begin fails++; $display("FAIL reset_dut3 got rdy %0b vld %0b exp 1 0", in_ready3, out_valid3); end
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_single();
        lane4[0] = 32'h11; lane4[1] = 32'h22; lane4[2] = 32'h33; lane4[3] = 32'h44;
        in_sel4 = 2'd2; in_valid4 = 1; out_ready4 = 1;
        cycle();
        in_valid4 = 0;
        tests++; if (out_valid4 !== 1'b1) begin fails++; $display("FAIL single_valid got %0b exp 1", out_valid4); end
        tests++; if (out_data4 !== 32'h33) begin fails++; $display("FAIL single_data got %h exp 33", out_data4); end
        cycle();
        tests++; if (out_valid4 !== 1'b0) begin fails++; $display("FAIL single_valid_drop got %0b exp 0", out_valid4); end
    endtask

    task automatic test_stream();
        out_ready4 = 1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) lane4[k] = $urandom;
            in_sel4 = 2'(i % 4); in_valid4 = 1;
            cycle();
            tests++; if (in_ready4 !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d] got %0b exp 1", i, in_ready4); end
            tests++; if (out_valid4 !== 1'b1 || exp_q.size() != 1 || out_data4 !== exp_q[0])
                begin fails++; $display("FAIL stream_data[%0d] got %h vld %0b exp %h", i, out_data4, out_valid4, (exp_q.size() > 0) ? exp_q[0] : 32'hx); end
        end
        in_valid4 = 0;
        cycle();
        tests++; if (out_valid4 !== 1'b0) begin fails++; $display("FAIL stream_drain got %0b exp 0", out_valid4); end
    endtask

    task automatic test_backpressure();
        logic [31:0] first;
        out_ready4 = 0; in_valid4 = 1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) lane4[k] = $urandom;
            in_sel4 = 2'($urandom_range(0, 3));
            cycle();
            if (i == 0) first = lane4[in_sel4];
            tests++; if (out_data4 !== first || out_valid4 !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d] got %h exp %h", i, out_data4, first); end
            tests++; if (in_ready4 !== (i == 0)) begin fails++; $display("FAIL bp_in_ready[%0d] got %0b exp %0b", i, in_ready4, (i == 0)); end
        end
        // third offer stays on the bus; release the output and drain
        out_ready4 = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) in_valid4 = 0;
            cycle();
            tests++; if (out_valid4 !== (exp_q.size() > 0)) begin fails++; $display("FAIL bp_drain_valid[%0d] got %0b exp %0b", i, out_valid4, (exp_q.size() > 0)); end
            tests++; if (exp_q.size() > 0 && out_data4 !== exp_q[0]) begin fails++; $display("FAIL bp_drain_data[%0d] got %h exp %h", i, out_data4, exp_q[0]); end
            tests++; if (in_ready4 !== (exp_q.size() < 2)) begin fails++; $display("FAIL bp_drain_ready[%0d] got %0b exp %0b", i, in_ready4, (exp_q.size() < 2)); end
        end
    endtask

    task automatic test_simul();
        logic [31:0] nv;
        out_ready4 = 1; in_valid4 = 1;
        for (int k = 0; k < 4; k++) lane4[k] = $urandom;
        in_sel4 = 2'd1;
        cycle();
        for (int k = 0; k < 4; k++) lane4[k] = $urandom;
        in_sel4 = 2'd3; nv = lane4[3];
        cycle();
        in_valid4 = 0;
        tests++; if (out_data4 !== nv || out_valid4 !== 1'b1) begin fails++; $display("FAIL simul_data got %h exp %h", out_data4, nv); end
        tests++; if (in_ready4 !== 1'b1) begin fails++; $display("FAIL simul_in_ready got %0b exp 1", in_ready4); end
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) lane4[k] = $urandom;
            in_sel4    = 2'($urandom_range(0, 3));
            in_valid4  = 1'($urandom_range(0, 1));
            out_ready4 = ($urandom_range(0, 3) != 0);
            cycle();
            tests++; if (out_valid4 !== (exp_q.size() > 0) || in_ready4 !== (exp_q.size() < 2))
                begin fails++; $display("FAIL rand_flags[%0d] got vld %0b rdy %0b exp occ %0d", i, out_valid4, in_ready4, exp_q.size()); end
            if (exp_q.size() > 0) begin
                tests++; if (out_data4 !== exp_q[0]) begin fails++; $display("FAIL rand_data[%0d] got %h exp %h", i, out_data4, exp_q[0]); end
            end
        end
        in_valid4 = 0; out_ready4 = 1;
        cycle(); cycle(); cycle();
        tests++; if (out_valid4 !== 1'b0 || sel_err4 !== 1'b0) begin fails++; $display("FAIL rand_end got vld %0b err %0b exp 0 0", out_valid4, sel_err4); end
    endtask

    task automatic test_oor();
        for (int k = 0; k < 3; k++) lane3[k] = $urandom | 32'h1;
        out_ready3 = 1; in_valid3 = 1; in_sel3 = 2'd3;
        cycle();
        in_valid3 = 0;
        tests++; if (out_valid3 !== 1'b1 || out_data3 !== 32'h0) begin fails++; $display("FAIL oor_data got %h vld %0b exp 0 1", out_data3, out_valid3); end
        tests++; if (sel_err3 !== EXP_ERR) begin fails++; $display("FAIL oor_sel_err got %0b exp %0b", sel_err3, EXP_ERR); end
        in_valid3 = 1; in_sel3 = 2'd2;
        cycle();
        in_valid3 = 0;
        tests++; if (out_data3 !== lane3[2]) begin fails++; $display("FAIL oor_lane2 got %h exp %h", out_data3, lane3[2]); end
        cycle(); cycle();
        tests++; if (sel_err3 !== EXP_ERR || out_valid3 !== 1'b0) begin fails++; $display("FAIL oor_sticky got err %0b vld %0b exp %0b 0", sel_err3, out_valid3, EXP_ERR); end
    endtask

    task automatic test_reset_mid();
        out_ready4 = 0; in_valid4 = 1;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) lane4[k] = $urandom | 32'h1;
            cycle();
        end
        tests++; if (in_ready4 !== 1'b0 || out_valid4 !== 1'b1) begin fails++; $display("FAIL rmid_full got rdy %0b vld %0b exp 0 1", in_ready4, out_valid4); end
        in_valid4 = 0;
        #3 rst_n = 1'b0;
        #1;
        tests++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out_data4 !== 32'h0)
            begin fails++; $display("FAIL rmid_async got vld %0b rdy %0b data %h exp 0 1 0", out_valid4, in_ready4, out_data4); end
        tests++; if (sel_err3 !== 1'b0) begin fails++; $display("FAIL rmid_sel_err got %0b exp 0", sel_err3); end
        #2 rst_n = 1'b1;
        exp_q.delete();
        out_ready4 = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin fails++; $display("FAIL rmid_after[%0d] got vld %0b rdy %0b exp 0 1", i, out_valid4, in_ready4); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_simul();
        test_random();
        test_oor();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Parametrised, registered N-way operand selector for the pipelined RV32 datapath; successor to the fixed 32-bit 4:1 selector.
- Selects one of N_IN data lanes per transfer using a binary select, then registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Used where a stage boundary and back-pressure are needed, e.g. forwarding-operand select feeding the EX/MEM stage or write-back source select.

Parameters:
- WIDTH, 32, data width of each lane and of the output.
- N_IN, 4, number of input lanes (2..16).
- SEL_W, $clog2(N_IN), select width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  N_IN*WIDTH  packed lanes; lane k = in_data[k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  lane index, sampled with in_valid.
- in_valid  in  1  upstream transfer request.
- in_ready  out  1  block can accept.
- out_data  out  WIDTH  selected, registered lane.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- sel_err  out  1  sticky out-of-range select flag. Only functional with PIPE_MUX_SELCHK_EN; otherwise tied to 0.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Combinational select:
  - sel_val = in_data lane in_sel when in_sel < N_IN.
  - sel_val = all-zero otherwise. This case is only reachable when N_IN is not a power of two.
- Storage is a main register (M) and a skid register (S), each with a valid bit.
- States: EMPTY (M and S invalid), ONE (M valid, S invalid), FULL (both valid).
- in_ready = !S.valid. It is driven from a flop (no combinational path from out_ready).
- Transitions:
  - EMPTY, input transfer -> ONE; M <= sel_val.
  - ONE, input only -> FULL; S <= sel_val.
  - ONE, output only -> EMPTY.
  - ONE, input and output -> ONE; M <= sel_val.
  - FULL, output transfer -> ONE; M <= S.
  - FULL: no input is accepted (in_ready = 0).
- out_valid = M.valid; out_data = M.data.
- Latency: 1 cycle from input transfer to out_valid when EMPTY.
- Throughput: 1 transfer/cycle when out_ready is held high.
- Ordering: strict FIFO; no transfer is dropped or duplicated.
- out_data is held stable while out_valid & !out_ready.
- Reset (async assert, synchronous deassert handled upstream) gives:
  - out_valid = 0, out_data = 0, in_ready = 1, sel_err = 0.
  - S.valid = 0, S.data = 0.
- Reset mid-operation discards all buffered data.
- in_valid while in_ready = 0: the input is ignored; upstream holds its data.

Optional Feature:
- Macro: PIPE_MUX_SELCHK_EN.
- Defined:
  - sel_err is set on any input transfer with in_sel >= N_IN.
  - sel_err stays set until rst_n asserts.
  - The zero word is still forwarded downstream.
- Undefined:
  - sel_err is constant 0 and no check logic is generated.
  - Out-of-range selects still yield zero data.

Decomposition:
- Shared package pipe_pkg holds:
  - Default constants DATA_W = 32, MUX_N_DEF = 4.
  - The SEL_W derivation function.
  - A typedef for the handshake state (EMPTY/ONE/FULL).
- One sub-module, skid_buf (params WIDTH), holds the M/S registers and handshake logic.
- pipe_mux_n = combinational lane select + skid_buf + optional check.

Test Plan:
- Reset, then single transfer:
  - Stimulus: N_IN=4, lanes = {0x44,0x33,0x22,0x11} (lane0 = 0x11), in_sel=2, in_valid for 1 cycle, out_ready=1.
  - Response: next cycle out_valid=1, out_data=0x33; the following cycle out_valid=0.
- Streaming:
  - Stimulus: 8 back-to-back transfers, sel = 0,1,2,3,0,1,2,3, out_ready=1.
  - Response: out_data follows the same lane sequence one cycle later; in_ready stays 1 throughout.
- Back-pressure:
  - Stimulus: out_ready=0, offer 3 transfers.
  - Response: first two accepted, in_ready falls after the second; out_data is held at the first value. On out_ready=1, values drain in order and the third transfer is then accepted.
- Simultaneous input and output in ONE:
  - Stimulus: out_ready=1 and a new input in the same cycle.
  - Response: stays ONE; out_data updates to the new value next cycle; no loss.
- Out-of-range select:
  - Stimulus: N_IN=3, in_sel=3.
  - Response: out_data = 0. sel_err = 1 (sticky) with PIPE_MUX_SELCHK_EN; sel_err = 0 without it.
- Reset mid-operation:
  - Stimulus: reach FULL, then pulse rst_n low asynchronously between clock edges.
  - Response: out_valid = 0 and in_ready = 1 immediately; no buffered data emerges after release.
